// File: rtl/braille_scroll_ctrl.sv
// Braille trainer scroll controller: buffers a code message and
// scrolls it left across DIGITS seven-segment decoder slots.
module braille_scroll_ctrl #(
  parameter int DIGITS   = 4,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50000000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Load_Valid,
  input  logic [3:0]          Load_Code,
  input  logic                Load_Last,
  output logic                Load_Ready,
  input  logic                Start,
  input  logic                Stop,
  output logic                Busy,
  output logic                Done,
  output logic [4*DIGITS-1:0] Digit_Code,
  output logic [DIGITS-1:0]   Digit_En
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SCROLL
  } state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [3:0]        buf_q [DEPTH];
  logic              accept;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [4*DIGITS-1:0] code_q, code_d;
  logic [DIGITS-1:0]   en_q, en_d;

  assign Load_Ready = (state_q == IDLE);
  assign accept     = Load_Valid && (state_q == IDLE);
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Digit_Code = code_q;
  assign Digit_En   = en_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_ptr_q <= '0;
      pos_q    <= '0;
      tick_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= '0;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      code_q   <= code_d;
      en_q     <= en_d;
    end
  end

  // Storage needs no reset: len gates every read.
  always_ff @(posedge Clk) begin
    if (Rst_n && accept) begin
      buf_q[wr_ptr_q] <= Load_Code;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    pos_d    = pos_q;
    tick_d   = tick_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Load_Valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          len_d    = len_q + 1'b1;
          if (Load_Last || len_q == LW'(DEPTH - 1)) begin
            state_d = LOADED;
          end
        end
      end
      LOADED: begin
        if (Stop) begin
          state_d  = IDLE;
          len_d    = '0;
          wr_ptr_d = '0;
        end else if (Start) begin
          state_d = SCROLL;
          pos_d   = '0;
          tick_d  = '0;
        end
      end
      SCROLL: begin
        if (Stop) begin
          state_d  = IDLE;
          len_d    = '0;
          wr_ptr_d = '0;
          pos_d    = '0;
          tick_d   = '0;
        end else if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (LW'(pos_q) + 1'b1 < len_q) begin
            pos_d = pos_q + 1'b1;
          end else begin
            state_d  = IDLE;
            done_d   = 1'b1;
            len_d    = '0;
            wr_ptr_d = '0;
            pos_d    = '0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Window is built from next-state so it lines up with Busy.
  always_comb begin
    busy_d = (state_d == SCROLL);
    code_d = '0;
    en_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      logic [LW-1:0] idx;
      logic [PW-1:0] addr;
      idx  = LW'(pos_d) + LW'(i);
      addr = pos_d + PW'(i);
      if (busy_d && idx < len_q) begin
        en_d[i]         = 1'b1;
        code_d[4*i +: 4] = buf_q[addr];
      end
    end
  end

endmodule

// File: tb/tb_braille_scroll_ctrl.sv
// Directed scoreboard bench for braille_scroll_ctrl with a
// short scroll step so whole messages fit in a few hundred cycles.
module tb_braille_scroll_ctrl;

  localparam int DIGITS = 4;
  localparam int DEPTH  = 16;
  localparam int TDIV   = 4;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Load_Valid;
  logic [3:0]  Load_Code;
  logic        Load_Last;
  logic        Load_Ready;
  logic        Start;
  logic        Stop;
  logic        Busy;
  logic        Done;
  logic [15:0] Digit_Code;
  logic [3:0]  Digit_En;

  typedef struct packed {
    logic [15:0] code;
    logic [3:0]  en;
  } win_t;

  win_t       exp_q[$];
  logic [3:0] msg[$];
  int         ntests = 0;
  int         nfail  = 0;

  braille_scroll_ctrl #(
    .DIGITS(DIGITS),
    .DEPTH(DEPTH),
    .TICK_DIV(TDIV)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Load_Valid(Load_Valid),
    .Load_Code(Load_Code),
    .Load_Last(Load_Last),
    .Load_Ready(Load_Ready),
    .Start(Start),
    .Stop(Stop),
    .Busy(Busy),
    .Done(Done),
    .Digit_Code(Digit_Code),
    .Digit_En(Digit_En)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_windows();
    win_t w;
    for (int p = 0; p < msg.size(); p++) begin
      w = '0;
      for (int i = 0; i < DIGITS; i++) begin
        if (p + i < msg.size()) begin
          w.en[i]         = 1'b1;
          w.code[4*i +: 4] = msg[p+i];
        end
      end
      for (int t = 0; t < TDIV; t++) exp_q.push_back(w);
    end
  endtask

  task automatic load_msg();
    for (int j = 0; j < msg.size(); j++) begin
      chk("load_ready", Load_Ready, 1);
      Load_Valid = 1'b1;
      Load_Code  = msg[j];
      Load_Last  = (j == msg.size() - 1);
      tick();
    end
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
    chk("loaded_ready", Load_Ready, 0);
  endtask

  task automatic scroll(input int start_at, input int load_at);
    win_t w;
    int   k;
    push_windows();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("win_code", Digit_Code, w.code);
      chk("win_en", Digit_En, w.en);
      chk("win_busy", Busy, 1);
      chk("win_done", Done, 0);
      Start      = (k == start_at);
      Load_Valid = (k == load_at);
      Load_Code  = 4'hF;
      tick();
      Start      = 1'b0;
      Load_Valid = 1'b0;
      k++;
    end
    chk("cmp_done", Done, 1);
    chk("cmp_busy", Busy, 0);
    chk("cmp_en", Digit_En, 0);
    chk("cmp_code", Digit_Code, 0);
    chk("cmp_ready", Load_Ready, 1);
    tick();
    chk("done_pulse", Done, 0);
  endtask

  initial begin
    int acc;
    int dones;
    Rst_n      = 1'b0;
    Load_Valid = 1'b1;
    Load_Code  = 4'h5;
    Load_Last  = 1'b1;
    Start      = 1'b0;
    Stop       = 1'b0;
    tick();
    tick();
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
    Rst_n      = 1'b1;
    chk("rst_ready", Load_Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_en", Digit_En, 0);
    chk("rst_code", Digit_Code, 0);
    chk("rst_done", Done, 0);

    // short message; also proves reset wrote nothing
    msg = '{4'hA};
    load_msg();
    scroll(-1, -1);

    msg = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    load_msg();
    scroll(-1, -1);

    // overflow: 20 valid cycles, only 16 accepted
    msg.delete();
    for (int j = 0; j < DEPTH; j++) msg.push_back(4'(j));
    acc        = 0;
    Load_Valid = 1'b1;
    Load_Last  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      Load_Code = 4'(c - 1);
      if (c >= 17) chk("ovf_ready", Load_Ready, 0);
      if (Load_Ready) acc++;
      tick();
    end
    Load_Valid = 1'b0;
    chk("ovf_beats", acc, 16);
    scroll(-1, -1);

    // abort 5 cycles into scroll
    msg = '{4'h7, 4'h8, 4'h9};
    load_msg();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("abort_pre_busy", Busy, 1);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_en", Digit_En, 0);
    chk("abort_code", Digit_Code, 0);
    chk("abort_done", Done, 0);
    chk("abort_ready", Load_Ready, 1);
    dones      = 0;
    Load_Valid = 1'b1;
    Load_Code  = 4'h3;
    Load_Last  = 1'b1;
    tick();
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
    chk("abort_reload", Load_Ready, 0);
    for (int c = 0; c < 20; c++) begin
      if (Done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);

    // Start+Stop together in LOADED: Stop wins
    Start = 1'b1;
    Stop  = 1'b1;
    tick();
    Stop = 1'b0;
    chk("prio_busy", Busy, 0);
    chk("prio_ready", Load_Ready, 1);
    tick();
    Start = 1'b0;
    chk("idle_start_ign", Busy, 0);

    // Start and Load_Valid mid-scroll are ignored
    msg = '{4'hB, 4'hC, 4'hD};
    load_msg();
    scroll(5, 3);

    // reset mid-scroll: no Done
    msg = '{4'h1, 4'h2};
    load_msg();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_en", Digit_En, 0);
    chk("rst_mid_ready", Load_Ready, 1);
    tick();
    chk("rst_mid_done", Done, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
